// File: rtl/online_r4_pkg.sv
// Shared definitions for the radix-4 online arithmetic slice (subtractor,
// on-the-fly converter, board tester).
package online_r4_pkg;

  localparam int C = 3;

  typedef logic signed [C-1:0] digit_t;

  localparam digit_t DIG_INVALID = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACC,
    ST_DONE
  } otf_state_e;

endpackage

// File: rtl/otf_step_r4.sv
// One Ercegovac on-the-fly conversion step: appends a signed radix-4 digit
// to the Q/QM pair using only shifts and muxes.
module otf_step_r4
  import online_r4_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] qm_in,
  input  digit_t       d,
  output logic [W-1:0] q_out,
  output logic [W-1:0] qm_out,
  output logic         illegal
);

  digit_t     dv;
  logic       neg;
  logic       pos;
  logic [1:0] lo;
  logic [1:0] lo_m1;

  // (4+d) mod 4 == d mod 4 and (3+d) mod 4 == (d-1) mod 4, so the appended
  // low bits are the same on both mux legs; only the source register differs.
  always_comb begin
    illegal = (d == DIG_INVALID);
    dv      = illegal ? digit_t'('0) : d;
    neg     = dv[C-1];
    pos     = !neg && (dv != digit_t'('0));
    lo      = dv[1:0];
    lo_m1   = lo - 2'd1;
    q_out   = neg ? {qm_in[W-3:0], lo}    : {q_in[W-3:0], lo};
    qm_out  = pos ? {q_in[W-3:0], lo_m1}  : {qm_in[W-3:0], lo_m1};
  end

endmodule

// File: rtl/otf_converter_r4.sv
// Converts the MSD-first signed radix-4 stream from online_sub_r4 into a
// registered two's-complement integer without a carry-propagate adder.
module otf_converter_r4
  import online_r4_pkg::*;
#(
  parameter  int N    = 7,
  parameter  int SKIP = 2,
  localparam int W    = 2*N+1,
  localparam int CW   = $clog2(N+SKIP+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                en,
  input  logic [C-1:0]        zi,
  output logic signed [W-1:0] q,
  output logic                valid,
  output logic                busy,
  output logic                err,
  output logic [CW-1:0]       count
);

  otf_state_e  state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  accm_q, accm_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [W-1:0] step_q;
  logic [W-1:0] step_qm;
  logic         step_illegal;

  otf_step_r4 #(.W(W)) u_step (
    .q_in    (acc_q),
    .qm_in   (accm_q),
    .d       (digit_t'(zi)),
    .q_out   (step_q),
    .qm_out  (step_qm),
    .illegal (step_illegal)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    accm_d  = accm_q;
    q_d     = q_q;
    count_d = count_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (start) begin
      state_d = (SKIP == 0) ? ST_ACC : ST_SKIP;
      acc_d   = '0;
      accm_d  = '1;
      q_d     = '0;
      count_d = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      err_d   = 1'b0;
    end else if (en) begin
      case (state_q)
        ST_SKIP: begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(SKIP-1)) state_d = ST_ACC;
        end
        ST_ACC: begin
          acc_d   = step_q;
          accm_d  = step_qm;
          count_d = count_q + CW'(1);
          if (step_illegal) err_d = 1'b1;
          if (count_q == CW'(SKIP+N-1)) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            q_d     = step_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      accm_q  <= '1;
      q_q     <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      accm_q  <= accm_d;
      q_q     <= q_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_otf_converter_r4.sv
// Directed bench for otf_converter_r4: arithmetic reference model checked
// every cycle, plus literal expectations for the documented vectors.
module tb_otf_converter_r4;
  localparam int N    = 7;
  localparam int SKIP = 2;
  localparam int W    = 2*N+1;
  localparam int CW   = $clog2(N+SKIP+1);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                en = 1'b0;
  logic [2:0]          zi = '0;
  logic signed [W-1:0] q;
  logic                valid;
  logic                busy;
  logic                err;
  logic [CW-1:0]       count;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state
  bit     m_armed = 1'b0;
  bit     m_valid = 1'b0;
  bit     m_err   = 1'b0;
  int     m_cnt   = 0;
  longint m_val   = 0;

  otf_converter_r4 #(.N(N), .SKIP(SKIP)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .en    (en),
    .zi    (zi),
    .q     (q),
    .valid (valid),
    .busy  (busy),
    .err   (err),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // value = sum of accepted digits weighted MSD-first; illegal digit counts as 0
  always @(posedge clk or posedge reset) begin
    int zs;
    if (reset) begin
      m_armed = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_val = 0;
    end else if (start) begin
      m_armed = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_val = 0;
    end else if (en && m_armed && !m_valid) begin
      if (m_cnt >= SKIP) begin
        zs = int'($signed(zi));
        if (zs == -4) begin
          m_err = 1'b1;
          zs = 0;
        end
        m_val = m_val * 4 + longint'(zs);
      end
      m_cnt++;
      if (m_cnt == SKIP + N) m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", longint'(valid), longint'(m_valid));
      check("busy", longint'(busy), longint'(m_armed && !m_valid));
      check("err", longint'(err), longint'(m_err));
      check("count", longint'(count), longint'(m_cnt));
      if (m_valid) check("q", longint'(q), m_val);
    end
  end

  task automatic step(input bit s, input bit e, input int d);
    start = s;
    en    = e;
    zi    = 3'(d);
    @(posedge clk);
    #2;
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic feed7(input int d1, input int d2, input int d3, input int d4,
                       input int d5, input int d6, input int d7);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, d1); step(0, 1, d2); step(0, 1, d3); step(0, 1, d4);
    step(0, 1, d5); step(0, 1, d6); step(0, 1, d7);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    check("reset_q", longint'(q), 0);
    check("reset_count", longint'(count), 0);
    check("reset_valid", longint'(valid), 0);
    reset = 1'b0;

    // 1: single leading 1
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check("lat_before_last", longint'(valid), 0);
    step(0, 1, 0);
    check("v1_valid", longint'(valid), 1);
    check("v1_q", longint'(q), 4096);
    check("v1_count", longint'(count), 9);
    check("v1_err", longint'(err), 0);
    step(0, 1, 3); step(0, 1, -3);
    check("done_hold_q", longint'(q), 4096);
    check("done_hold_count", longint'(count), 9);

    // 2: negative digit through QM
    step(1, 0, 0);
    feed7(1, -1, 0, 0, 0, 0, 0);
    check("v2_q", longint'(q), 3072);

    // 3: extremes
    step(1, 0, 0);
    feed7(-3, -3, -3, -3, -3, -3, -3);
    check("v3_min", longint'(q), -16383);
    step(1, 0, 0);
    feed7(3, 3, 3, 3, 3, 3, 3);
    check("v3_max", longint'(q), 16383);

    // 4: small value, then same with a stall
    step(1, 0, 0);
    feed7(0, 0, 0, 0, 0, 1, -2);
    check("v4_q", longint'(q), 2);
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 3); step(0, 0, -1); step(0, 0, -4);
    check("v4_stall_count", longint'(count), 5);
    check("v4_stall_valid", longint'(valid), 0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 1); step(0, 1, -2);
    check("v4_stall_q", longint'(q), 2);

    // 5: illegal digit
    step(1, 0, 0);
    feed7(1, -4, 0, 0, 0, 0, 0);
    check("v5_err", longint'(err), 1);
    check("v5_q", longint'(q), 4096);
    step(1, 0, 0);
    check("v5_err_clr", longint'(err), 0);

    // 6: restart mid-ACC, digit in start cycle discarded
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 1); step(0, 1, 2); step(0, 1, 3); step(0, 1, 1);
    step(1, 1, 3);
    check("v6_count", longint'(count), 0);
    check("v6_busy", longint'(busy), 1);
    feed7(2, 0, 0, 0, 0, 0, 0);
    check("v6_q", longint'(q), 8192);

    // 7: async reset mid-ACC with err set
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 1, -4); step(0, 1, 1); step(0, 1, 1);
    check("v7_err_pre", longint'(err), 1);
    reset = 1'b1;
    #1;
    check("v7_q", longint'(q), 0);
    check("v7_valid", longint'(valid), 0);
    check("v7_busy", longint'(busy), 0);
    check("v7_err", longint'(err), 0);
    check("v7_count", longint'(count), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(0, 1, 1); step(0, 1, 1);
    check("v7_idle_count", longint'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otf_converter_r4.md
Name: otf_converter_r4

Overview:
Downstream stage of online_sub_r4. Consumes its MSD-first signed radix-4 digit stream zi and converts it on the fly into a conventional two's-complement integer. It uses the Ercegovac Q/QM scheme, so there is no carry-propagate adder. Replaces the ad-hoc result packing in the board test controller with a registered, self-checking conversion.

Parameters:
N, 7, result digits to accumulate (operand digits n=6, plus 1)
C, 3, bits per signed digit (two's complement, legal range -3..+3)
SKIP, 2, leading enabled cycles discarded (online delay of the subtractor)
W, 2*N+1, output width (derived; the module does not override it)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  synchronous clear/arm for a new conversion
en  in  1  a digit is presented on zi this cycle
zi  in  C  signed radix-4 digit from online_sub_r4
q  out  W  signed converted value sum d_j*4^(N-j), j=1..N
valid  out  1  q final; level, held until start or reset
busy  out  1  high in SKIP or ACC state
err  out  1  sticky: an illegal digit (-4, 3'b100) was accepted
count  out  $clog2(N+SKIP+1)  enabled cycles consumed since start

Behaviour:
- Reset (async): state=IDLE, Q=0, QM=all ones (-1), count=0, q=0, valid=0, busy=0, err=0.
- States: IDLE, SKIP, ACC, DONE.
  - IDLE: outputs idle. start -> SKIP, or -> ACC if SKIP=0.
  - SKIP: each en increments count; zi is ignored. When SKIP digits have been consumed, next state is ACC.
  - ACC: each en applies one OTF step and increments count. The step that takes the digit total to N -> DONE.
  - DONE: valid=1, q=Q. Further en is ignored and count is frozen. start -> SKIP/ACC.
- start has priority in every state. It clears Q=0, QM=-1, count=0, err=0 and valid=0, and any same-cycle en/zi is discarded. start and en in the same cycle count as start only.
- en low: no state change (stall allowed in any state).
- OTF step, digit d:
  - Q' = (d>=0) ? {Q, d[1:0]} : {QM, (4+d)[1:0]}
  - QM' = (d>0) ? {Q, (d-1)[1:0]} : {QM, (3+d)[1:0]}
  - Shifts are left by 2 with truncation to W bits. Only concatenation/mux is used, no adder across W.
- Invalid digit 3'b100 accepted in ACC: err<=1 (sticky), and the digit is treated as 0. In SKIP it is ignored and err is not set.
- Latency: valid rises one cycle after the en carrying the Nth accumulated digit. q is registered and equals Q in that cycle.
- Range: |value| <= 4^N-1, so W=2N+1 never overflows.
- Reset mid-conversion aborts immediately with no partial valid.
- busy=0 in IDLE and DONE.

Decomposition:
- Shared package online_r4_pkg:
  - constant C=3
  - digit typedef (signed [C-1:0])
  - DIG_INVALID=3'b100
  - state enum {IDLE, SKIP, ACC, DONE}
  - This package is also used by online_sub_r4 and the tester.
- One combinational sub-module, otf_step_r4: inputs Q, QM, d; outputs Q', QM', illegal flag. It lets the bench check the step exhaustively in isolation.

Test Plan:
- reset, start, en=1 each cycle, zi = 0,0 (skipped), then 1,0,0,0,0,0,0 -> valid high 1 cycle after 9th en; q=4096, err=0, count=9.
- start, zi = 0,0, then 1,-1,0,0,0,0,0 -> q=3072 (exercises QM path on negative digit).
- start, zi = 0,0, then -3 x7 -> q=-16383; then 3 x7 after a new start -> q=16383.
- start, zi = 0,0, then 0,0,0,0,0,1,-2 -> q=2. Repeat with en deasserted for 3 cycles mid-stream -> same q, count stalls.
- start, zi = 0,0, then 1,3'b100,0,0,0,0,0 -> err=1, q=4096. A following start clears err.
- Mid-ACC after 4 digits, assert start with en=1, zi=3 -> digit discarded and count=0. Then feed 0,0,2,0,0,0,0,0,0 -> q=8192. Also assert async reset mid-ACC -> all outputs 0 immediately, no valid.
